bytebeat_mixer_pwm: RTL and testbench
=====================================

BYTEBEAT_MIXER_PWM -- requirements
Module: bytebeat_mixer_pwm

Interface
REQ-001 SHALL have parameter NCH, default 8: number of PCM channels, 2..16.
REQ-002 SHALL have parameter SW, default 8: sample width in bits, which also sets the PWM frame length of 2^SW clocks.
REQ-003 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 s_data  in  NCH*SW  per-channel unsigned PCM sample; channel i occupies bits [i*SW +: SW].
REQ-007 s_vld  in  NCH  per-channel sample valid.
REQ-008 s_rdy  out  NCH  per-channel ready.
REQ-009 ch_en  in  NCH  per-channel mix enable.
REQ-010 ch_att  in  2*NCH  per-channel attenuation, right shift 0..3.
REQ-011 mode  in  1  0 = mix, 1 = solo.
REQ-012 solo_sel  in  clog2(NCH)  channel routed in solo mode.
REQ-013 urun_clr  in  1  clears all underrun flags.
REQ-014 mix_out  out  SW  mixed sample currently driving PWM.
REQ-015 mix_vld  out  1  one-cycle pulse marking a new mix_out.
REQ-016 pwm_out  out  1  PWM of mix_out.
REQ-017 pwm_ch  out  NCH  per-channel PWM of the held samples.
REQ-018 underrun  out  NCH  sticky per-channel underrun flags.

Function
REQ-019 Frame counter cnt (SW bits) SHALL increment every clock and wrap from 2^SW-1 to 0; LAST means cnt == 2^SW-1.
REQ-020 Each channel SHALL have a 1-entry buffer buf[i] with a full flag; s_rdy[i] = !full[i].
REQ-021 A transfer occurs when s_vld[i] && s_rdy[i]: buf[i] takes s_data, full[i] is set on the next edge.
REQ-022 At LAST with full[i] set: hold[i] <= buf[i] and full[i] is cleared.
REQ-023 At LAST with full[i] clear: hold[i] is unchanged and underrun[i] is set.
REQ-024 A transfer on the LAST cycle (buffer was empty) SHALL fill the buffer only; it is consumed at the next LAST and SHALL NOT flag underrun at the current LAST.
REQ-025 underrun[i] SHALL stay set until urun_clr; a set event and urun_clr in the same cycle resolve to set.
REQ-026 On the cycle with cnt == 0, mix_out SHALL register the mix of hold[], and mix_vld SHALL pulse high for exactly the following cycle (cnt == 1).
REQ-027 Mix mode: mix_out = min(2^SW-1, sum over i of (ch_en[i] ? hold[i] >> ch_att[i] : 0)), with the accumulator at least SW+clog2(NCH) bits and no wrap.
REQ-028 Solo mode: mix_out = hold[solo_sel] >> ch_att[solo_sel], ignoring ch_en; solo_sel >= NCH SHALL yield 0.
REQ-029 ch_en, ch_att, mode and solo_sel SHALL be sampled only on the cnt == 0 cycle; changes take effect next frame.
REQ-030 pwm_out SHALL be registered: pwm_out(k+1) = (cnt(k) < mix_out(k)); duty D gives exactly D high cycles per 2^SW frame; D = 0 gives constant low.
REQ-031 pwm_ch[i] SHALL be registered with the same rule, using hold[i] unattenuated.
REQ-032 Latency from a sample's transfer to its first effect on pwm_ch is at most 2^SW+2 clocks; on pwm_out it is at most 2^SW+3 clocks.

Reset
REQ-033 While reset is high: cnt = 0, full = 0, buf = 0, hold = 0, mix_out = 0, mix_vld = 0, pwm_out = 0, pwm_ch = 0, underrun = 0, s_rdy = 0.
REQ-034 Reset asserted mid-frame SHALL discard buffered samples immediately, with no partial PWM pulse after release.
REQ-035 s_rdy SHALL go to all-ones on the first clock edge after reset deasserts; cnt starts at 0 on that edge.

Verification
REQ-036 NCH=8, SW=8, mode=0, all enabled, att=0, ch0=0x40 and ch1=0x30 loaded each frame, others 0 -> mix_out=0x70 and mix_vld pulses once per 256 clocks; pwm_out high 112 of 256 cycles.
REQ-037 Saturation: all 8 channels loaded with 0x80, att=0 -> mix_out=0xFF; then set ch_att=1 on all -> mix_out=0xFF (8*0x40 saturates); then ch_en=0x01 -> mix_out=0x40 in the frame after.
REQ-038 Solo: mode=1, solo_sel=3, ch3=0xA0, ch_att[3]=2 -> mix_out=0x28 regardless of ch_en=0.
REQ-039 Underrun: feed ch2 for one frame only -> hold[2] is retained, underrun[2] sets at the next LAST, and clears on urun_clr pulse; simultaneous set and clear -> stays set.
REQ-040 Boundary and reset: transfer on the LAST cycle lands in the next frame with no underrun; reset asserted at cnt=0x80 -> all outputs 0 asynchronously and s_rdy=0xFF one edge after release.

Source files
------------

// File: rtl/bytebeat_mixer_pwm.sv
// Multi-channel PCM mixer: per-channel one-deep buffers feed frame-held samples
// that are mixed (saturating or solo) once per 2^SW-clock frame and rendered as PWM.
`timescale 1ns/1ps
module bytebeat_mixer_pwm #(
    parameter int NCH = 8,
    parameter int SW  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH*SW-1:0]        s_data,
    input  logic [NCH-1:0]           s_vld,
    output logic [NCH-1:0]           s_rdy,
    input  logic [NCH-1:0]           ch_en,
    input  logic [2*NCH-1:0]         ch_att,
    input  logic                     mode,
    input  logic [$clog2(NCH)-1:0]   solo_sel,
    input  logic                     urun_clr,
    output logic [SW-1:0]            mix_out,
    output logic                     mix_vld,
    output logic                     pwm_out,
    output logic [NCH-1:0]           pwm_ch,
    output logic [NCH-1:0]           underrun
);

    localparam int AW = SW + $clog2(NCH) + 1;
    localparam logic [SW-1:0] SMAX = '1;

    logic              run_q, run_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [NCH-1:0]    full_q, full_d;
    logic [SW-1:0]     buf_q [NCH];
    logic [SW-1:0]     buf_d [NCH];
    logic [SW-1:0]     hold_q [NCH];
    logic [SW-1:0]     hold_d [NCH];
    logic [SW-1:0]     mix_q, mix_d;
    logic              mix_vld_q, mix_vld_d;
    logic              pwm_q, pwm_d;
    logic [NCH-1:0]    pwm_ch_q, pwm_ch_d;
    logic [NCH-1:0]    urun_q, urun_d;

    logic [NCH-1:0]    xfer;
    logic              last;
    logic              frame0;
    logic [AW-1:0]     acc;
    logic [SW-1:0]     shv;
    logic [SW-1:0]     solo_v;
    logic [SW-1:0]     mix_val;

    always_comb begin
        // run_q gates the first post-reset edge so the frame starts at cnt == 0
        s_rdy    = run_q ? ~full_q : '0;
        xfer     = s_vld & s_rdy;
        last     = run_q && (cnt_q == SMAX);
        frame0   = run_q && (cnt_q == '0);
        run_d    = 1'b1;
        cnt_d    = run_q ? cnt_q + SW'(1) : '0;
        full_d   = full_q;
        buf_d    = buf_q;
        hold_d   = hold_q;
        urun_d   = urun_q & ~{NCH{urun_clr}};
        pwm_ch_d = '0;
        acc      = '0;
        shv      = '0;
        solo_v   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (xfer[i]) begin
                buf_d[i]  = s_data[i*SW +: SW];
                full_d[i] = 1'b1;
            end
            // A transfer landing on the LAST cycle fills the buffer and suppresses underrun
            if (last) begin
                if (full_q[i]) begin
                    hold_d[i] = buf_q[i];
                    full_d[i] = 1'b0;
                end else if (!xfer[i]) begin
                    urun_d[i] = 1'b1;
                end
            end
            shv = hold_q[i] >> ch_att[2*i +: 2];
            if (ch_en[i]) acc = acc + AW'(shv);
            if (32'(solo_sel) == i) solo_v = shv;
            pwm_ch_d[i] = (cnt_q < hold_q[i]);
        end
        if (mode) mix_val = solo_v;
        else      mix_val = (acc > AW'(SMAX)) ? SMAX : acc[SW-1:0];
        mix_d     = frame0 ? mix_val : mix_q;
        mix_vld_d = frame0;
        pwm_d     = (cnt_q < mix_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            full_q    <= '0;
            buf_q     <= '{default: '0};
            hold_q    <= '{default: '0};
            mix_q     <= '0;
            mix_vld_q <= 1'b0;
            pwm_q     <= 1'b0;
            pwm_ch_q  <= '0;
            urun_q    <= '0;
        end else begin
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            buf_q     <= buf_d;
            hold_q    <= hold_d;
            mix_q     <= mix_d;
            mix_vld_q <= mix_vld_d;
            pwm_q     <= pwm_d;
            pwm_ch_q  <= pwm_ch_d;
            urun_q    <= urun_d;
        end
    end

    assign mix_out  = mix_q;
    assign mix_vld  = mix_vld_q;
    assign pwm_out  = pwm_q;
    assign pwm_ch   = pwm_ch_q;
    assign underrun = urun_q;

endmodule

// File: tb/tb_bytebeat_mixer_pwm.sv
// Directed bench for bytebeat_mixer_pwm (NCH=8, SW=8): mixing, saturation, solo,
// underrun stickiness, LAST-cycle transfer and mid-frame reset.
`timescale 1ns/1ps
module tb_bytebeat_mixer_pwm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] s_data = '0;
    logic [7:0]  s_vld = '0;
    logic [7:0]  s_rdy;
    logic [7:0]  ch_en = 8'hFF;
    logic [15:0] ch_att = '0;
    logic        mode = 1'b0;
    logic [2:0]  solo_sel = '0;
    logic        urun_clr = 1'b0;
    logic [7:0]  mix_out;
    logic        mix_vld;
    logic        pwm_out;
    logic [7:0]  pwm_ch;
    logic [7:0]  underrun;

    int checks = 0;
    int errors = 0;

    // Reference frame position: first edge after release is cnt 0, then +1 per clock
    logic [7:0] tcnt;
    logic       trun;

    bytebeat_mixer_pwm #(.NCH(8), .SW(8)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
        .ch_en(ch_en), .ch_att(ch_att), .mode(mode), .solo_sel(solo_sel),
        .urun_clr(urun_clr), .mix_out(mix_out), .mix_vld(mix_vld),
        .pwm_out(pwm_out), .pwm_ch(pwm_ch), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
            trun <= 1'b0;
        end else begin
            trun <= 1'b1;
            if (trun) tcnt <= tcnt + 8'd1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_cnt(input logic [7:0] v);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            if (tcnt == v) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt timeout waiting for cnt %h", v);
        end
    endtask

    task automatic load(input logic [7:0] mask, input logic [63:0] data);
        bit done;
        done = 1'b0;
        s_data = data;
        s_vld  = mask;
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clk);
            begin
                logic [7:0] took;
                took = s_vld & s_rdy;
                @(posedge clk);
                #1 s_vld = s_vld & ~took;
            end
            if (s_vld == 8'h00) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL load timeout pending %h", s_vld);
            s_vld = '0;
        end
    endtask

    // Ends at the cnt==1 negedge right after the next mix register update
    task automatic next_frame_vld(input string name, input logic [7:0] exp);
        wait_cnt(8'hFF);
        wait_cnt(8'h01);
        checks++;
        if (mix_vld !== 1'b1) begin
            errors++;
            $display("FAIL %s_vld got %b exp 1", name, mix_vld);
        end
        checks++;
        if (mix_out !== exp) begin
            errors++;
            $display("FAIL %s_mix got %h exp %h", name, mix_out, exp);
        end
    endtask

    // Window cnt 2 .. cnt 1 of next frame: one full PWM period of the new mix_out
    task automatic count_frame(output int hi, output int vld, output int ch0);
        hi = 0; vld = 0; ch0 = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            hi  += int'(pwm_out);
            vld += int'(mix_vld);
            ch0 += int'(pwm_ch[0]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mix_out, mix_vld, pwm_out, pwm_ch, underrun, s_rdy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got mix %h vld %b pwm %b ch %h ur %h rdy %h exp all 0",
                     mix_out, mix_vld, pwm_out, pwm_ch, underrun, s_rdy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s_rdy !== 8'hFF) begin
            errors++;
            $display("FAIL reset_rdy got %h exp ff", s_rdy);
        end
    endtask

    task automatic test_mix();
        int hi, vld, ch0;
        load(8'hFF, 64'h0000_0000_0000_3040);
        next_frame_vld("mix", 8'h70);
        count_frame(hi, vld, ch0);
        checks++;
        if (hi != 112) begin
            errors++;
            $display("FAIL mix_pwm_high got %0d exp 112", hi);
        end
        checks++;
        if (vld != 1) begin
            errors++;
            $display("FAIL mix_vld_count got %0d exp 1", vld);
        end
        checks++;
        if (ch0 != 64) begin
            errors++;
            $display("FAIL mix_pwm_ch0 got %0d exp 64", ch0);
        end
    endtask

    task automatic test_saturation();
        int hi, vld, ch0;
        load(8'hFF, {8{8'h80}});
        next_frame_vld("sat", 8'hFF);
        ch_att = 16'h5555;
        next_frame_vld("sat_att", 8'hFF);
        count_frame(hi, vld, ch0);
        checks++;
        if (hi != 255) begin
            errors++;
            $display("FAIL sat_pwm_high got %0d exp 255", hi);
        end
        ch_en = 8'h01;
        next_frame_vld("sat_en", 8'h40);
    endtask

    task automatic test_solo();
        mode     = 1'b1;
        solo_sel = 3'd3;
        ch_en    = 8'h00;
        ch_att   = 16'h0080;
        load(8'h08, 64'h0000_0000_A000_0000);
        next_frame_vld("solo", 8'h28);
    endtask

    task automatic test_underrun();
        solo_sel = 3'd2;
        ch_att   = '0;
        ch_en    = 8'hFF;
        @(posedge clk); #1 urun_clr = 1'b1;
        @(posedge clk); #1 urun_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (underrun !== 8'h00) begin
            errors++;
            $display("FAIL urun_clr1 got %h exp 00", underrun);
        end
        load(8'h04, 64'h0000_0000_0055_0000);
        wait_cnt(8'h00);
        checks++;
        if (underrun !== 8'hFB) begin
            errors++;
            $display("FAIL urun_fed got %h exp fb", underrun);
        end
        wait_cnt(8'h01);
        checks++;
        if (mix_out !== 8'h55) begin
            errors++;
            $display("FAIL urun_hold got %h exp 55", mix_out);
        end
        wait_cnt(8'h00);
        checks++;
        if (underrun !== 8'hFF) begin
            errors++;
            $display("FAIL urun_set got %h exp ff", underrun);
        end
        wait_cnt(8'h01);
        checks++;
        if (mix_out !== 8'h55) begin
            errors++;
            $display("FAIL urun_retain got %h exp 55", mix_out);
        end
        @(posedge clk); #1 urun_clr = 1'b1;
        @(posedge clk); #1 urun_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (underrun !== 8'h00) begin
            errors++;
            $display("FAIL urun_clr2 got %h exp 00", underrun);
        end
        wait_cnt(8'hFE);
        @(posedge clk); #1 urun_clr = 1'b1;
        @(posedge clk); #1 urun_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (underrun !== 8'hFF) begin
            errors++;
            $display("FAIL urun_set_vs_clr got %h exp ff", underrun);
        end
    endtask

    task automatic test_last_transfer();
        @(posedge clk); #1 urun_clr = 1'b1;
        @(posedge clk); #1 urun_clr = 1'b0;
        wait_cnt(8'hFE);
        @(posedge clk);
        #1;
        s_data   = 64'h0000_3300_0000_0000;
        s_vld    = 8'h20;
        solo_sel = 3'd5;
        @(posedge clk);
        #1 s_vld = '0;
        @(negedge clk);
        checks++;
        if (underrun !== 8'hDF) begin
            errors++;
            $display("FAIL last_urun got %h exp df", underrun);
        end
        checks++;
        if (s_rdy !== 8'hDF) begin
            errors++;
            $display("FAIL last_rdy got %h exp df", s_rdy);
        end
        wait_cnt(8'h01);
        checks++;
        if (mix_out !== 8'h80) begin
            errors++;
            $display("FAIL last_old_hold got %h exp 80", mix_out);
        end
        next_frame_vld("last_new", 8'h33);
        checks++;
        if (underrun !== 8'hDF) begin
            errors++;
            $display("FAIL last_no_urun got %h exp df", underrun);
        end
    endtask

    task automatic test_midframe_reset();
        int hi, vld, ch0;
        load(8'h01, 64'h0000_0000_0000_0099);
        wait_cnt(8'h80);
        checks++;
        if (pwm_ch !== 8'hDB) begin
            errors++;
            $display("FAIL pre_reset_pwm_ch got %h exp db", pwm_ch);
        end
        checks++;
        if (s_rdy !== 8'hFE) begin
            errors++;
            $display("FAIL pre_reset_rdy got %h exp fe", s_rdy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mix_out, mix_vld, pwm_out, pwm_ch, underrun, s_rdy} !== '0) begin
            errors++;
            $display("FAIL async_reset got mix %h vld %b pwm %b ch %h ur %h rdy %h exp all 0",
                     mix_out, mix_vld, pwm_out, pwm_ch, underrun, s_rdy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mode  = 1'b0;
        #1;
        checks++;
        if (s_rdy !== 8'h00) begin
            errors++;
            $display("FAIL rdy_before_edge got %h exp 00", s_rdy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_rdy !== 8'hFF) begin
            errors++;
            $display("FAIL rdy_after_edge got %h exp ff", s_rdy);
        end
        next_frame_vld("post_reset", 8'h00);
        count_frame(hi, vld, ch0);
        checks++;
        if (hi != 0 || ch0 != 0) begin
            errors++;
            $display("FAIL post_reset_pwm got out %0d ch0 %0d exp 0 0", hi, ch0);
        end
        checks++;
        if (underrun !== 8'hFF) begin
            errors++;
            $display("FAIL post_reset_urun got %h exp ff", underrun);
        end
    endtask

    initial begin
        test_reset();
        test_mix();
        test_saturation();
        test_solo();
        test_underrun();
        test_last_transfer();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
